pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the RISC-V core, the successor to the single-register PC block. It holds the fetch address and selects the next one by fixed priority from trap, return-from-trap, jump, branch and sequential increment. It also provides stall and fetch-ready hold, a boot cycle, a halt state, an EPC capture register and misaligned-target detection. It sits between the branch/jump resolution logic and the instruction memory address port.

## Interface
- XLEN, 32, address/data width in bits
- RESET_VEC, 0, PC value after reset
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect
- SUPPORT_C, 0, 1 = 2-byte instruction alignment, 0 = 4-byte alignment
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- stall  input  1  hold PC (pipeline hazard)
- fetch_ready  input  1  instruction memory accepts the current address
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  XLEN  branch destination
- jump  input  1  JAL/JALR redirect
- jump_target  input  XLEN  jump destination
- trap  input  1  exception/interrupt request
- xret  input  1  return from trap; PC <= epc
- halt  input  1  enter HALT (ebreak/wfi)
- resume  input  1  leave HALT
- pc  output  XLEN  current fetch address
- pc_plus  output  XLEN  pc + 4, combinational, wraps mod 2^XLEN
- fetch_valid  output  1  pc is a valid fetch request
- epc  output  XLEN  captured PC of the faulting/trapping instruction
- misaligned_exc  output  1  one-cycle pulse: a redirect target was misaligned
- halted  output  1  state == HALT

## Operation
- States: BOOT, RUN, HALT. Encoding is free; `halted` is a decode of the state.
- Reset (async, rst=0): pc=RESET_VEC, epc=0, state=BOOT, fetch_valid=0, misaligned_exc=0, halted=0.
- BOOT: exactly one cycle after reset release, then RUN. pc stays RESET_VEC. Every input is ignored, including trap.
- RUN: fetch_valid=1. adv = fetch_ready & ~stall. Next-PC priority:
  1. trap: pc<=TRAP_VEC, epc<=pc. Applies even when adv=0.
  2. xret & adv: pc<=epc.
  3. jump & adv: pc<=jump_target.
  4. branch_taken & adv: pc<=branch_target.
  5. halt & adv: pc<=pc_plus, state<=HALT.
  6. adv: pc<=pc_plus.
  7. else: hold.
- Misalignment: a target is misaligned when target[1:0]!=0 (SUPPORT_C=0) or target[0]!=0 (SUPPORT_C=1).
  - A misaligned jump_target or branch_target in rules 3/4 gives pc<=TRAP_VEC, epc<=pc (the redirecting instruction), misaligned_exc=1 for the following cycle.
  - xret to a misaligned epc is not checked; the lowest alignment bits are cleared.
- HALT: fetch_valid=0, pc held.
  - trap: pc<=TRAP_VEC, epc<=pc, state<=RUN.
  - else resume: state<=RUN.
  - All other inputs are ignored.
- Arithmetic is unsigned mod 2^XLEN, so PC wraps from all-ones-minus-3 to 0 with no flag.

## Timing
- All state, pc, epc and misaligned_exc updates occur on the rising edge of clk. pc_plus is the only combinational output.
- Redirect latency is 1 cycle: a request sampled at edge N makes pc show the target after edge N.
- misaligned_exc is asserted in the same cycle that pc shows TRAP_VEC and is low in every other cycle.
- Simultaneous trap+jump+stall: trap wins. pc=TRAP_VEC next cycle, epc=old pc.
- Simultaneous halt+branch_taken: the branch wins and the state stays RUN.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously), and BOOT repeats after release.
- fetch_ready=0 holds pc and keeps fetch_valid=1; the address must stay stable until it is accepted.

## Test plan
- Reset release, fetch_ready=1, no requests -> pc 0 (BOOT), 0, 4, 8, 12 on successive cycles; fetch_valid low only in the BOOT cycle.
- pc=0x20, jump=1, jump_target=0x400 -> pc=0x400 next cycle; with stall=1 the same request -> pc stays 0x20.
- pc=0x40, branch_taken=1, branch_target=0x102 (SUPPORT_C=0) -> pc=0x100 (TRAP_VEC), epc=0x40, misaligned_exc=1 for one cycle; with SUPPORT_C=1 -> pc=0x102, no exception.
- pc=0x80, trap=1, jump=1, stall=1 -> pc=0x100, epc=0x80. Next, xret=1 -> pc=0x80.
- pc=0x10, halt=1 -> pc=0x14, halted=1, fetch_valid=0, held for 5 cycles; resume=1 -> RUN and pc advances to 0x18.
- XLEN=32, pc=0xFFFF_FFFC, adv -> pc=0x0000_0000; rst pulsed low mid-stream -> pc=RESET_VEC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address and selects the next one by fixed priority
// (trap, xret, jump, branch, increment), with boot/run/halt sequencing and EPC capture.
module pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter bit              SUPPORT_C = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            trap,
  input  logic            xret,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic            misaligned_exc,
  output logic            halted
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(SUPPORT_C ? 1 : 3);

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] epc_reg, epc_next;
  logic            exc_reg, exc_next;
  logic            adv;

  function automatic logic misaligned(input logic [1:0] lo);
    return SUPPORT_C ? lo[0] : (lo != 2'b00);
  endfunction

  assign adv     = fetch_ready & ~stall;
  assign pc_plus = pc_reg + XLEN'(4);

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    epc_next   = epc_reg;
    exc_next   = 1'b0;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        // Trap is honoured even while stalled; every other redirect waits for adv.
        if (trap) begin
          pc_next  = TRAP_VEC;
          epc_next = pc_reg;
        end else if (xret && adv) begin
          pc_next = epc_reg & ALIGN_MASK;
        end else if (jump && adv) begin
          if (misaligned(jump_target[1:0])) begin
            pc_next  = TRAP_VEC;
            epc_next = pc_reg;
            exc_next = 1'b1;
          end else begin
            pc_next = jump_target;
          end
        end else if (branch_taken && adv) begin
          if (misaligned(branch_target[1:0])) begin
            pc_next  = TRAP_VEC;
            epc_next = pc_reg;
            exc_next = 1'b1;
          end else begin
            pc_next = branch_target;
          end
        end else if (halt && adv) begin
          pc_next    = pc_plus;
          state_next = ST_HALT;
        end else if (adv) begin
          pc_next = pc_plus;
        end
      end
      ST_HALT: begin
        if (trap) begin
          pc_next    = TRAP_VEC;
          epc_next   = pc_reg;
          state_next = ST_RUN;
        end else if (resume) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_BOOT;
      pc_reg    <= RESET_VEC;
      epc_reg   <= '0;
      exc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      epc_reg   <= epc_next;
      exc_reg   <= exc_next;
    end
  end

  assign pc             = pc_reg;
  assign epc            = epc_reg;
  assign misaligned_exc = exc_reg;
  assign fetch_valid    = (state_reg == ST_RUN);
  assign halted         = (state_reg == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (4-byte and 2-byte alignment) share stimulus and are
// compared against a behavioural next-PC model.
module tb_pc_unit;

  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] TRAP_VEC  = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, fetch_ready, branch_taken, jump, trap, xret, halt, resume;
  logic [31:0] branch_target, jump_target;

  logic [31:0] pc_o[2], pcp_o[2], epc_o[2];
  logic        fv_o[2], exc_o[2], hlt_o[2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state, per instance (0: 4-byte alignment, 1: 2-byte alignment)
  logic [31:0] m_pc[2], m_epc[2];
  bit          m_boot[2], m_halt[2], m_exc[2];

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .SUPPORT_C(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap(trap), .xret(xret),
    .halt(halt), .resume(resume), .pc(pc_o[0]), .pc_plus(pcp_o[0]),
    .fetch_valid(fv_o[0]), .epc(epc_o[0]), .misaligned_exc(exc_o[0]), .halted(hlt_o[0]));

  pc_unit #(.XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .SUPPORT_C(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .trap(trap), .xret(xret),
    .halt(halt), .resume(resume), .pc(pc_o[1]), .pc_plus(pcp_o[1]),
    .fetch_valid(fv_o[1]), .epc(epc_o[1]), .misaligned_exc(exc_o[1]), .halted(hlt_o[1]));

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_pc[c] = RESET_VEC; m_epc[c] = 32'h0;
      m_boot[c] = 1'b1; m_halt[c] = 1'b0; m_exc[c] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      int unsigned align = (c == 1) ? 2 : 4;
      logic [31:0] np = m_pc[c];
      logic [31:0] ne = m_epc[c];
      bit          adv = fetch_ready && !stall;
      bit          ex = 1'b0;
      if (m_boot[c]) begin
        m_boot[c] = 1'b0;
      end else if (m_halt[c]) begin
        if (trap) begin np = TRAP_VEC; ne = m_pc[c]; m_halt[c] = 1'b0; end
        else if (resume) m_halt[c] = 1'b0;
      end else if (trap) begin
        np = TRAP_VEC; ne = m_pc[c];
      end else if (xret && adv) begin
        np = (m_epc[c] / align) * align;
      end else if ((jump || branch_taken) && adv) begin
        logic [31:0] t = jump ? jump_target : branch_target;
        if (t % align != 0) begin np = TRAP_VEC; ne = m_pc[c]; ex = 1'b1; end
        else np = t;
      end else if (halt && adv) begin
        np = m_pc[c] + 4; m_halt[c] = 1'b1;
      end else if (adv) begin
        np = m_pc[c] + 4;
      end
      m_pc[c] = np; m_epc[c] = ne; m_exc[c] = ex;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    cyc++;
    $display("[TB] cyc=%0d pc0=%h pc1=%h epc0=%h epc1=%h fv=%b%b exc=%b%b hlt=%b%b",
             cyc, pc_o[0], pc_o[1], epc_o[0], epc_o[1], fv_o[0], fv_o[1],
             exc_o[0], exc_o[1], hlt_o[0], hlt_o[1]);
  endtask

  task automatic idle();
    stall = 0; fetch_ready = 1; branch_taken = 0; jump = 0; trap = 0;
    xret = 0; halt = 0; resume = 0; branch_target = 0; jump_target = 0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    idle(); jump = 1; jump_target = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      tests++; if (pc_o[c] !== RESET_VEC || epc_o[c] !== 32'h0) begin fails++;
        $display("FAIL reset_state[%0d] pc=%h epc=%h exp pc=%h epc=0", c, pc_o[c], epc_o[c], RESET_VEC); end
      tests++; if (fv_o[c] !== 1'b0 || exc_o[c] !== 1'b0 || hlt_o[c] !== 1'b0) begin fails++;
        $display("FAIL reset_flags[%0d] fv=%b exc=%b hlt=%b exp 0 0 0", c, fv_o[c], exc_o[c], hlt_o[c]); end
    end
    rst = 1;
    begin
      logic [31:0] exp_seq[5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        tests++; if (pc_o[0] !== exp_seq[i] || fv_o[0] !== (i != 0)) begin fails++;
          $display("FAIL boot_seq[%0d] pc=%h fv=%b exp pc=%h fv=%b", i, pc_o[0], fv_o[0], exp_seq[i], i != 0); end
      end
    end
  endtask

  task automatic test_jump();
    goto_pc(32'h20);
    jump = 1; jump_target = 32'h400; stall = 1;
    step();
    tests++; if (pc_o[0] !== 32'h20) begin fails++;
      $display("FAIL jump_stalled pc=%h exp=%h", pc_o[0], 32'h20); end
    stall = 0;
    step();
    tests++; if (pc_o[0] !== 32'h400 || pc_o[1] !== 32'h400) begin fails++;
      $display("FAIL jump pc0=%h pc1=%h exp=%h", pc_o[0], pc_o[1], 32'h400); end
    idle();
  endtask

  task automatic test_branch_misaligned();
    goto_pc(32'h40);
    branch_taken = 1; branch_target = 32'h102;
    step();
    tests++; if (pc_o[0] !== TRAP_VEC || epc_o[0] !== 32'h40 || exc_o[0] !== 1'b1) begin fails++;
      $display("FAIL branch_mis_c0 pc=%h epc=%h exc=%b exp pc=%h epc=40 exc=1", pc_o[0], epc_o[0], exc_o[0], TRAP_VEC); end
    tests++; if (pc_o[1] !== 32'h102 || exc_o[1] !== 1'b0) begin fails++;
      $display("FAIL branch_c1 pc=%h exc=%b exp pc=102 exc=0", pc_o[1], exc_o[1]); end
    idle();
    step();
    tests++; if (exc_o[0] !== 1'b0 || pc_o[0] !== TRAP_VEC + 4) begin fails++;
      $display("FAIL exc_pulse exc=%b pc=%h exp exc=0 pc=%h", exc_o[0], pc_o[0], TRAP_VEC + 4); end
  endtask

  task automatic test_trap_xret();
    goto_pc(32'h80);
    trap = 1; jump = 1; jump_target = 32'h200; stall = 1;
    step();
    tests++; if (pc_o[0] !== TRAP_VEC || epc_o[0] !== 32'h80 || exc_o[0] !== 1'b0) begin fails++;
      $display("FAIL trap_prio pc=%h epc=%h exc=%b exp pc=%h epc=80 exc=0", pc_o[0], epc_o[0], exc_o[0], TRAP_VEC); end
    idle(); xret = 1;
    step();
    tests++; if (pc_o[0] !== 32'h80 || pc_o[1] !== 32'h80) begin fails++;
      $display("FAIL xret pc0=%h pc1=%h exp=80", pc_o[0], pc_o[1]); end
    idle();
  endtask

  task automatic test_halt();
    goto_pc(32'h10);
    halt = 1;
    step();
    tests++; if (pc_o[0] !== 32'h14 || hlt_o[0] !== 1'b1 || fv_o[0] !== 1'b0) begin fails++;
      $display("FAIL halt_enter pc=%h hlt=%b fv=%b exp pc=14 hlt=1 fv=0", pc_o[0], hlt_o[0], fv_o[0]); end
    idle(); jump = 1; jump_target = 32'h300; branch_taken = 1; branch_target = 32'h304; xret = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (pc_o[0] !== 32'h14 || hlt_o[0] !== 1'b1) begin fails++;
        $display("FAIL halt_hold[%0d] pc=%h hlt=%b exp pc=14 hlt=1", i, pc_o[0], hlt_o[0]); end
    end
    idle(); resume = 1;
    step();
    tests++; if (hlt_o[0] !== 1'b0 || fv_o[0] !== 1'b1 || pc_o[0] !== 32'h14) begin fails++;
      $display("FAIL resume hlt=%b fv=%b pc=%h exp hlt=0 fv=1 pc=14", hlt_o[0], fv_o[0], pc_o[0]); end
    idle();
    step();
    tests++; if (pc_o[0] !== 32'h18) begin fails++;
      $display("FAIL resume_adv pc=%h exp=18", pc_o[0]); end
    halt = 1; branch_taken = 1; branch_target = 32'h600;
    step();
    tests++; if (pc_o[0] !== 32'h600 || hlt_o[0] !== 1'b0) begin fails++;
      $display("FAIL halt_vs_branch pc=%h hlt=%b exp pc=600 hlt=0", pc_o[0], hlt_o[0]); end
    idle();
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    fetch_ready = 0;
    step();
    tests++; if (pc_o[0] !== 32'hFFFF_FFFC || fv_o[0] !== 1'b1 || pcp_o[0] !== 32'h0) begin fails++;
      $display("FAIL not_ready pc=%h fv=%b pc_plus=%h exp pc=fffffffc fv=1 pc_plus=0", pc_o[0], fv_o[0], pcp_o[0]); end
    fetch_ready = 1;
    step();
    tests++; if (pc_o[0] !== 32'h0) begin fails++;
      $display("FAIL wrap pc=%h exp=0", pc_o[0]); end
  endtask

  task automatic test_async_reset();
    step(); step();
    #3 rst = 0;
    #1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      tests++; if (pc_o[c] !== RESET_VEC || epc_o[c] !== 32'h0 || fv_o[c] !== 1'b0 || hlt_o[c] !== 1'b0 || exc_o[c] !== 1'b0) begin fails++;
        $display("FAIL async_reset[%0d] pc=%h epc=%h fv=%b hlt=%b exc=%b exp all reset", c, pc_o[c], epc_o[c], fv_o[c], hlt_o[c], exc_o[c]); end
    end
    @(posedge clk); #1;
    rst = 1;
    step();
    tests++; if (pc_o[0] !== RESET_VEC || fv_o[0] !== 1'b1) begin fails++;
      $display("FAIL reboot pc=%h fv=%b exp pc=%h fv=1", pc_o[0], fv_o[0], RESET_VEC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      fetch_ready   = ($urandom % 4) != 0;
      stall         = ($urandom % 5) == 0;
      trap          = ($urandom % 20) == 0;
      xret          = ($urandom % 12) == 0;
      jump          = ($urandom % 6) == 0;
      branch_taken  = ($urandom % 5) == 0;
      halt          = ($urandom % 15) == 0;
      resume        = ($urandom % 3) == 0;
      jump_target   = ($urandom & 32'h0000_0FFC) + ((($urandom % 3) == 0) ? ($urandom % 4) : 0);
      branch_target = ($urandom & 32'h0000_0FFC) + ((($urandom % 3) == 0) ? ($urandom % 4) : 0);
      step();
      for (int c = 0; c < 2; c++) begin
        tests++;
        if (pc_o[c] !== m_pc[c] || pcp_o[c] !== m_pc[c] + 32'd4 || epc_o[c] !== m_epc[c] ||
            fv_o[c] !== (!m_boot[c] && !m_halt[c]) || exc_o[c] !== m_exc[c] || hlt_o[c] !== m_halt[c]) begin
          fails++;
          $display("FAIL random[%0d][%0d] pc=%h epc=%h fv=%b exc=%b hlt=%b exp pc=%h epc=%h fv=%b exc=%b hlt=%b",
                   i, c, pc_o[c], epc_o[c], fv_o[c], exc_o[c], hlt_o[c],
                   m_pc[c], m_epc[c], !m_boot[c] && !m_halt[c], m_exc[c], m_halt[c]);
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch_misaligned();
    test_trap_xret();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
